uart_rx_frame_checker: RTL and testbench
========================================

# uart_rx_frame_checker

Sequential, parametrised UART receive frame checker. It consumes the bit stream produced by the receiver's bit sampler, one sampled bit per strobe. It walks each frame through start, data, parity and stop fields, checks every field, and delivers the data word with per-frame error flags over a valid/ready handshake. It sits between the RX sampler and the RX FIFO or host interface, and optionally keeps saturating error statistics.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame, legal 5..9, LSB first on the line.
- STOP_BITS, 1: stop bits per frame, legal 1 or 2.
- CNT_WIDTH, 8: width of each error counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- bit_valid  in  1  single-cycle strobe: bit_in holds one sampled line bit.
- bit_in  in  1  sampled line bit.
- sof  in  1  qualifies bit_valid; that bit is the start bit.
- parity_type  in  2  01 odd, 10 even, 00/11 no parity field.
- rx_ready  in  1  downstream accepts rx_data.
- clr_counts  in  1  synchronous clear of all counters.
- rx_data  out  DATA_WIDTH  received word.
- rx_valid  out  1  rx_data/error_flag valid.
- error_flag  out  3  [0] parity, [1] start, [2] stop error; valid with rx_valid.
- overrun  out  1  one-cycle pulse: completed frame dropped.
- busy  out  1  frame in progress (state != IDLE).
- parity_err_cnt, frame_err_cnt, overrun_cnt  out  CNT_WIDTH each  error statistics.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP1, STOP2. Transitions happen only on bit_valid.
- Frame start:
  - IDLE + bit_valid&sof: record start_err = bit_in, latch parity_type into a frame-local register, clear the bit counter, go to DATA.
  - IDLE + bit_valid without sof: ignored.
- DATA: shift bit_in into position bitcnt (LSB first) and accumulate XOR. After DATA_WIDTH bits, go to PARITY if the latched type is 01/10, else STOP1.
- PARITY:
  - Odd type: error when (XOR of data ^ bit_in) == 0.
  - Even type: error when it == 1.
  - Go to STOP1.
- STOP1:
  - stop_err = ~bit_in.
  - STOP_BITS==2 → STOP2; STOP2 ORs in ~bit_in.
  - The last stop bit completes the frame; return to IDLE.
- No-parity frames: error_flag[0] = 0.
- Completion with an empty buffer, or with a full buffer while rx_ready is high:
  - load rx_data and error_flag, assert rx_valid.
  - Frames with errors are still delivered, with their flags set.
- Completion with rx_valid high and rx_ready low:
  - frame dropped, buffer unchanged, overrun pulses for 1 cycle.
- Handshake:
  - rx_valid && rx_ready clears rx_valid unless a new frame loads in the same cycle.
  - rx_data and error_flag stay stable while rx_valid is high and rx_ready is low.
- sof with bit_valid in any non-IDLE state:
  - current frame aborted with no output.
  - new frame starts from that bit (same cycle, as from IDLE).
- Changes on parity_type mid-frame have no effect on the frame in progress.

## Timing
- Reset values:
  - State IDLE; busy 0.
  - rx_valid 0, rx_data 0, error_flag 000, overrun 0.
  - All counters 0.
- Latency: rx_valid rises on the clock edge that samples the last stop bit's bit_valid; visible the next cycle.
- Throughput: one bit per bit_valid. bit_valid may be asserted on consecutive cycles.
- busy rises the cycle after the sof edge and falls the cycle after the completing edge.
- Counter updates occur on the completion or abort edge.
- Reset asserted mid-frame: immediate return to reset values. Any partial frame and any buffered word are lost.

## Configuration
- UART_ERR_COUNTERS_EN defined:
  - Counters are implemented and saturate at all-ones.
  - parity_err_cnt: +1 per completed frame with a parity error.
  - frame_err_cnt: +1 per completed frame with a start or stop error, and +1 per aborted frame.
  - overrun_cnt: +1 per dropped frame.
  - Dropped frames still count their parity/frame errors.
  - clr_counts wins over a simultaneous increment (result 0).
- UART_ERR_COUNTERS_EN undefined: no counter flops; all counter outputs tied to 0; clr_counts ignored.

## Test plan
- DATA_WIDTH=8, even parity, frame start 0, data 0xA5, parity 0, stop 1, rx_ready=1 → rx_data=0xA5, error_flag=000, rx_valid 1 cycle.
- Odd parity, data 0x01: parity bit 0 → error_flag=000; parity bit 1 → error_flag=001, parity_err_cnt=1.
- Frames with start bit 1, then a frame with stop bit 0 (STOP_BITS=2, second stop bit 0) → error_flag=010 then 100, frame_err_cnt=2; frames still delivered.
- rx_ready=0 and two complete frames 0x11 then 0x22 → rx_data stays 0x11, overrun pulses once, overrun_cnt=1; raise rx_ready → 0x11 accepted, rx_valid drops.
- sof after 3 data bits, then a full frame 0x3C → only 0x3C delivered, frame_err_cnt=1; reset_n low mid-frame → all outputs 0, busy 0.
- Counter saturation: CNT_WIDTH=2 and 5 parity-error frames → parity_err_cnt=3; clr_counts coincident with a 6th error → 0.

Source files
------------

// File: rtl/uart_rx_frame_checker_if.sv
// Receive-side handshake bundle: framed word plus error flags under valid/ready.
interface uart_rx_frame_checker_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [2:0]            error_flag;

  modport master (output rx_data, output rx_valid, output error_flag, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input error_flag, output rx_ready);
endinterface

// File: rtl/uart_rx_frame_checker.sv
// UART RX frame checker: walks start/data/parity/stop fields and delivers word + error flags.
// Optional saturating error statistics are built when UART_ERR_COUNTERS_EN is defined.
module uart_rx_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 bit_valid,
  input  logic                 bit_in,
  input  logic                 sof,
  input  logic [1:0]           parity_type,
  input  logic                 clr_counts,
  uart_rx_frame_checker_if.master rx_if,
  output logic                 overrun,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] parity_err_cnt,
  output logic [CNT_WIDTH-1:0] frame_err_cnt,
  output logic [CNT_WIDTH-1:0] overrun_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DATA   = 3'd1;
  localparam logic [2:0] S_PARITY = 3'd2;
  localparam logic [2:0] S_STOP1  = 3'd3;
  localparam logic [2:0] S_STOP2  = 3'd4;
  localparam int         BCW      = 4;

  logic [2:0]            state_q, state_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  xor_q, xor_d;
  logic [1:0]            ptype_q, ptype_d;
  logic                  start_err_q, start_err_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [2:0]            err_q, err_d;
  logic                  overrun_q, overrun_d;

  logic                  frame_done;
  logic                  frame_abort;
  logic                  frame_drop;
  logic [2:0]            done_flags;

  function automatic logic has_parity(input logic [1:0] t);
    return (t == 2'b01) || (t == 2'b10);
  endfunction

  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    xor_d       = xor_q;
    ptype_d     = ptype_q;
    start_err_d = start_err_q;
    par_err_d   = par_err_q;
    stop_err_d  = stop_err_q;
    frame_done  = 1'b0;
    frame_abort = 1'b0;
    done_flags  = {stop_err_q, start_err_q, par_err_q};
    if (bit_valid) begin
      if (sof) begin
        // A start bit always restarts framing, discarding any frame in flight.
        frame_abort = (state_q != S_IDLE);
        state_d     = S_DATA;
        bitcnt_d    = '0;
        shift_d     = '0;
        xor_d       = 1'b0;
        ptype_d     = parity_type;
        start_err_d = bit_in;
        par_err_d   = 1'b0;
        stop_err_d  = 1'b0;
      end else begin
        case (state_q)
          S_DATA: begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
              if (bitcnt_q == BCW'(i)) shift_d[i] = bit_in;
            end
            xor_d    = xor_q ^ bit_in;
            bitcnt_d = bitcnt_q + BCW'(1);
            if (bitcnt_q == BCW'(DATA_WIDTH - 1)) begin
              state_d = has_parity(ptype_q) ? S_PARITY : S_STOP1;
            end
          end
          S_PARITY: begin
            par_err_d = (ptype_q == 2'b01) ? ~(xor_q ^ bit_in) : (xor_q ^ bit_in);
            state_d   = S_STOP1;
          end
          S_STOP1: begin
            stop_err_d = ~bit_in;
            if (STOP_BITS == 2) begin
              state_d = S_STOP2;
            end else begin
              state_d    = S_IDLE;
              frame_done = 1'b1;
            end
          end
          S_STOP2: begin
            stop_err_d = stop_err_q | ~bit_in;
            state_d    = S_IDLE;
            frame_done = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
        done_flags = {stop_err_d, start_err_q, par_err_q};
      end
    end
  end

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    overrun_d  = 1'b0;
    frame_drop = 1'b0;
    if (frame_done && (!rx_valid_q || rx_if.rx_ready)) begin
      rx_valid_d = 1'b1;
      rx_data_d  = shift_q;
      err_d      = done_flags;
    end else if (frame_done) begin
      frame_drop = 1'b1;
      overrun_d  = 1'b1;
    end else if (rx_valid_q && rx_if.rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      xor_q       <= 1'b0;
      ptype_q     <= 2'b00;
      start_err_q <= 1'b0;
      par_err_q   <= 1'b0;
      stop_err_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      err_q       <= 3'b000;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      xor_q       <= xor_d;
      ptype_q     <= ptype_d;
      start_err_q <= start_err_d;
      par_err_q   <= par_err_d;
      stop_err_q  <= stop_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.error_flag = err_q;
  assign overrun          = overrun_q;
  assign busy             = (state_q != S_IDLE);

`ifdef UART_ERR_COUNTERS_EN
  logic [CNT_WIDTH-1:0] par_cnt_q, frm_cnt_q, ovr_cnt_q;
  logic                 inc_par, inc_frm, inc_ovr;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
    return (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  // Dropped frames still carry their own error classification.
  assign inc_par = frame_done & done_flags[0];
  assign inc_frm = (frame_done & (done_flags[1] | done_flags[2])) | frame_abort;
  assign inc_ovr = frame_drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else if (clr_counts) begin
      par_cnt_q <= '0;
      frm_cnt_q <= '0;
      ovr_cnt_q <= '0;
    end else begin
      par_cnt_q <= sat_inc(par_cnt_q, inc_par);
      frm_cnt_q <= sat_inc(frm_cnt_q, inc_frm);
      ovr_cnt_q <= sat_inc(ovr_cnt_q, inc_ovr);
    end
  end

  assign parity_err_cnt = par_cnt_q;
  assign frame_err_cnt  = frm_cnt_q;
  assign overrun_cnt    = ovr_cnt_q;
`else
  logic unused_cnt_inputs;
  assign unused_cnt_inputs = ^{clr_counts, frame_abort, frame_drop};
  assign parity_err_cnt    = '0;
  assign frame_err_cnt     = '0;
  assign overrun_cnt       = '0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_checker.sv
// Bench for uart_rx_frame_checker: two instances (1 and 2 stop bits) share one bit stream
// and are compared each cycle against a frame-level model, plus directed literal checks.
module tb_uart_rx_frame_checker;

`ifdef UART_ERR_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       bit_valid, bit_in, sof, clr_counts, rx_ready;
  logic [1:0] parity_type;

  logic       ovr0, busy0, ovr1, busy1;
  logic [7:0] pc0, fc0, oc0;
  logic [1:0] pc1, fc1, oc1;

  int n_tests = 0;
  int n_fail  = 0;

  uart_rx_frame_checker_if #(.DATA_WIDTH(8)) if0 ();
  uart_rx_frame_checker_if #(.DATA_WIDTH(8)) if1 ();
  assign if0.rx_ready = rx_ready;
  assign if1.rx_ready = rx_ready;

  uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(1), .CNT_WIDTH(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .parity_type(parity_type), .clr_counts(clr_counts), .rx_if(if0),
    .overrun(ovr0), .busy(busy0),
    .parity_err_cnt(pc0), .frame_err_cnt(fc0), .overrun_cnt(oc0));

  uart_rx_frame_checker #(.DATA_WIDTH(8), .STOP_BITS(2), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .bit_valid(bit_valid), .bit_in(bit_in), .sof(sof),
    .parity_type(parity_type), .clr_counts(clr_counts), .rx_if(if1),
    .overrun(ovr1), .busy(busy1),
    .parity_err_cnt(pc1), .frame_err_cnt(fc1), .overrun_cnt(oc1));

  always #5 clk = ~clk;

  // ---------------- frame-level model ----------------
  int       SB[2]   = '{1, 2};
  int       CMAX[2] = '{255, 3};
  bit       m_act[2];
  int       m_n[2];
  bit       m_bits[2][16];
  bit [1:0] m_pt[2];
  bit       m_valid[2];
  int       m_data[2];
  int       m_flags[2];
  bit       m_ovr[2];
  int       m_pc[2], m_fc[2], m_oc[2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 0; m_n[k] = 0; m_pt[k] = 0;
      m_valid[k] = 0; m_data[k] = 0; m_flags[k] = 0; m_ovr[k] = 0;
      m_pc[k] = 0; m_fc[k] = 0; m_oc[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit done = 0, abort = 0, se = 0, pe = 0, ste = 0, haspar;
      int len, data = 0, ones = 0;
      m_ovr[k] = 0;
      if (bit_valid) begin
        if (sof) begin
          abort    = m_act[k];
          m_act[k] = 1;
          m_pt[k]  = parity_type;
          m_n[k]   = 0;
        end
        if (m_act[k]) begin
          m_bits[k][m_n[k]] = bit_in;
          m_n[k]++;
        end
        haspar = (m_pt[k] == 2'b01) || (m_pt[k] == 2'b10);
        len = 1 + 8 + (haspar ? 1 : 0) + SB[k];
        if (m_act[k] && m_n[k] == len) begin
          done = 1;
          m_act[k] = 0;
          for (int i = 0; i < 8; i++) begin
            data |= int'(m_bits[k][1+i]) << i;
            ones += int'(m_bits[k][1+i]);
          end
          se = m_bits[k][0];
          if (haspar) begin
            ones += int'(m_bits[k][9]);
            pe = (m_pt[k] == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1);
          end
          for (int j = len - SB[k]; j < len; j++) if (!m_bits[k][j]) ste = 1;
        end
      end
      if (done) begin
        if (!m_valid[k] || rx_ready) begin
          m_valid[k] = 1; m_data[k] = data; m_flags[k] = {29'd0, ste, se, pe};
        end else begin
          m_ovr[k] = 1;
        end
      end else if (m_valid[k] && rx_ready) begin
        m_valid[k] = 0;
      end
      if (CNT_EN) begin
        if (clr_counts) begin
          m_pc[k] = 0; m_fc[k] = 0; m_oc[k] = 0;
        end else begin
          if (done && pe && m_pc[k] < CMAX[k]) m_pc[k]++;
          if (((done && (se || ste)) || abort) && m_fc[k] < CMAX[k]) m_fc[k]++;
          if (m_ovr[k] && m_oc[k] < CMAX[k]) m_oc[k]++;
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : cmp
    logic [31:0] av, ad, ae, ao, ab, ap, af, ac;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) begin
        av = 32'(if0.rx_valid); ad = 32'(if0.rx_data); ae = 32'(if0.error_flag);
        ao = 32'(ovr0); ab = 32'(busy0); ap = 32'(pc0); af = 32'(fc0); ac = 32'(oc0);
      end else begin
        av = 32'(if1.rx_valid); ad = 32'(if1.rx_data); ae = 32'(if1.error_flag);
        ao = 32'(ovr1); ab = 32'(busy1); ap = 32'(pc1); af = 32'(fc1); ac = 32'(oc1);
      end
      chk($sformatf("d%0d.rx_valid", k), av, 32'(m_valid[k]));
      chk($sformatf("d%0d.rx_data", k), ad, m_data[k]);
      chk($sformatf("d%0d.error_flag", k), ae, m_flags[k]);
      chk($sformatf("d%0d.overrun", k), ao, 32'(m_ovr[k]));
      chk($sformatf("d%0d.busy", k), ab, 32'(m_act[k]));
      chk($sformatf("d%0d.parity_err_cnt", k), ap, m_pc[k]);
      chk($sformatf("d%0d.frame_err_cnt", k), af, m_fc[k]);
      chk($sformatf("d%0d.overrun_cnt", k), ac, m_oc[k]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit bv, input bit b, input bit s);
    @(negedge clk);
    bit_valid = bv; bit_in = b; sof = s;
    @(posedge clk);
    model_step();
    #1;
    bit_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  // Sends start, data, optional parity and the first stop bit; the caller sends stop 2.
  task automatic send_head(input bit st, input logic [7:0] d, input bit pb, input bit s1,
                           input bit chg);
    bit par = (parity_type == 2'b01) || (parity_type == 2'b10);
    step(1, st, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, d[i], 0);
      if (chg && i == 3) parity_type = 2'b00;
    end
    if (par) step(1, pb, 0);
    step(1, s1, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst.d0.busy", 32'(busy0), 0);
    chk("rst.d0.rx_valid", 32'(if0.rx_valid), 0);
    chk("rst.d0.rx_data", 32'(if0.rx_data), 0);
    chk("rst.d0.error_flag", 32'(if0.error_flag), 0);
    chk("rst.d0.overrun", 32'(ovr0), 0);
    chk("rst.d0.frame_err_cnt", 32'(fc0), 0);
    chk("rst.d1.busy", 32'(busy1), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; bit_valid = 0; bit_in = 0; sof = 0; clr_counts = 0;
    rx_ready = 1; parity_type = 2'b10;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.d0.rx_valid", 32'(if0.rx_valid), 0);
    chk("reset.d0.rx_data", 32'(if0.rx_data), 0);
    chk("reset.d0.error_flag", 32'(if0.error_flag), 0);
    chk("reset.d0.overrun", 32'(ovr0), 0);
    chk("reset.d1.busy", 32'(busy1), 0);
    reset_n = 1'b1;
    idle(2);

    // Even parity, 0xA5
    send_head(0, 8'hA5, 0, 1, 0);
    chk("a5.d0.rx_valid", 32'(if0.rx_valid), 1);
    chk("a5.d0.rx_data", 32'(if0.rx_data), 32'hA5);
    chk("a5.d0.error_flag", 32'(if0.error_flag), 0);
    step(1, 1, 0);
    chk("a5.d0.rx_valid_drop", 32'(if0.rx_valid), 0);
    chk("a5.d1.rx_valid", 32'(if1.rx_valid), 1);
    chk("a5.d1.rx_data", 32'(if1.rx_data), 32'hA5);
    idle(2);

    // Odd parity, 0x01, good then bad parity bit
    parity_type = 2'b01;
    send_head(0, 8'h01, 0, 1, 0);
    chk("odd_ok.d0.error_flag", 32'(if0.error_flag), 0);
    step(1, 1, 0);
    idle(1);
    send_head(0, 8'h01, 1, 1, 0);
    chk("odd_bad.d0.error_flag", 32'(if0.error_flag), 1);
    chk("odd_bad.d0.parity_err_cnt", 32'(pc0), CNT_EN ? 1 : 0);
    step(1, 1, 0);
    chk("odd_bad.d1.error_flag", 32'(if1.error_flag), 1);
    idle(1);

    // Start error, then second-stop error (seen only by the 2-stop instance)
    parity_type = 2'b10;
    send_head(1, 8'h00, 0, 1, 0);
    chk("start.d0.error_flag", 32'(if0.error_flag), 2);
    step(1, 1, 0);
    chk("start.d1.error_flag", 32'(if1.error_flag), 2);
    idle(1);
    send_head(0, 8'h00, 0, 1, 0);
    chk("stop2.d0.error_flag", 32'(if0.error_flag), 0);
    step(1, 0, 0);
    chk("stop2.d1.error_flag", 32'(if1.error_flag), 4);
    chk("stop2.d1.rx_valid", 32'(if1.rx_valid), 1);
    chk("stop2.d1.frame_err_cnt", 32'(fc1), CNT_EN ? 2 : 0);
    idle(1);

    // Overrun with rx_ready low
    rx_ready = 0;
    idle(1);
    send_head(0, 8'h11, 0, 1, 0);
    chk("ovr.d0.rx_data1", 32'(if0.rx_data), 32'h11);
    step(1, 1, 0);
    send_head(0, 8'h22, 0, 1, 0);
    chk("ovr.d0.overrun", 32'(ovr0), 1);
    chk("ovr.d0.rx_data_hold", 32'(if0.rx_data), 32'h11);
    step(1, 1, 0);
    chk("ovr.d0.overrun_pulse_end", 32'(ovr0), 0);
    chk("ovr.d1.rx_data_hold", 32'(if1.rx_data), 32'h11);
    chk("ovr.d0.overrun_cnt", 32'(oc0), CNT_EN ? 1 : 0);
    rx_ready = 1;
    step(0, 0, 0);
    chk("ovr.d0.rx_valid_drop", 32'(if0.rx_valid), 0);
    chk("ovr.d1.rx_valid_drop", 32'(if1.rx_valid), 0);

    // Clear, then abort after 3 data bits; parity_type changes mid-frame
    clr_counts = 1;
    step(0, 0, 0);
    clr_counts = 0;
    chk("clr.d0.frame_err_cnt", 32'(fc0), 0);
    step(1, 0, 1);
    step(1, 1, 0);
    step(1, 0, 0);
    step(1, 1, 0);
    chk("abort.d0.busy", 32'(busy0), 1);
    send_head(0, 8'h3C, 0, 1, 1);
    chk("abort.d0.rx_data", 32'(if0.rx_data), 32'h3C);
    chk("abort.d0.error_flag", 32'(if0.error_flag), 0);
    step(1, 1, 0);
    chk("abort.d1.rx_data", 32'(if1.rx_data), 32'h3C);
    chk("abort.d0.frame_err_cnt", 32'(fc0), CNT_EN ? 1 : 0);
    chk("abort.d1.frame_err_cnt", 32'(fc1), CNT_EN ? 1 : 0);

    // No-parity frame (parity_type left at 00 by the previous frame)
    send_head(0, 8'h5A, 0, 1, 0);
    chk("nopar.d0.rx_data", 32'(if0.rx_data), 32'h5A);
    chk("nopar.d0.error_flag", 32'(if0.error_flag), 0);
    step(1, 1, 0);
    idle(1);

    // Reset mid-frame
    step(1, 0, 1);
    repeat (4) step(1, 1, 0);
    do_reset();
    idle(2);

    // Saturation: five parity errors, then a sixth coincident with clear
    parity_type = 2'b10;
    repeat (5) begin
      send_head(0, 8'h01, 0, 1, 0);
      step(1, 1, 0);
    end
    chk("sat.d1.parity_err_cnt", 32'(pc1), CNT_EN ? 3 : 0);
    chk("sat.d0.parity_err_cnt", 32'(pc0), CNT_EN ? 5 : 0);
    clr_counts = 1;
    send_head(0, 8'h01, 0, 1, 0);
    chk("satclr.d0.error_flag", 32'(if0.error_flag), 1);
    chk("satclr.d0.parity_err_cnt", 32'(pc0), 0);
    step(1, 1, 0);
    clr_counts = 0;
    chk("satclr.d1.parity_err_cnt", 32'(pc1), 0);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
